// File: rtl/codec_config_sequencer_pkg.sv
// rtl/codec_config_sequencer_pkg.sv - shared types and constants for the SSM2603 config sequencer
package codec_config_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_START,
        ST_ADDR,
        ST_REG,
        ST_DATA,
        ST_STOP,
        ST_NEXT,
        ST_ERR_STOP,
        ST_DONE,
        ST_FAIL
    } state_e;

    localparam int ENTRY_W = 16;

    localparam logic [6:0] CODEC_DEVICE_ADDR = 7'h1A;

    // SSM2603 register numbers
    localparam logic [6:0] REG_LOUT_VOL     = 7'd2;
    localparam logic [6:0] REG_ROUT_VOL     = 7'd3;
    localparam logic [6:0] REG_ANALOG_PATH  = 7'd4;
    localparam logic [6:0] REG_DIGITAL_PATH = 7'd5;
    localparam logic [6:0] REG_POWER_MGMT   = 7'd6;
    localparam logic [6:0] REG_DIGITAL_IF   = 7'd7;
    localparam logic [6:0] REG_SAMPLING     = 7'd8;
    localparam logic [6:0] REG_ACTIVE       = 7'd9;
    localparam logic [6:0] REG_SW_RESET     = 7'd15;

    // I2C write-address byte: 7-bit device address followed by R/W=0
    function automatic logic [7:0] write_addr_byte(input logic [6:0] dev_addr);
        return {dev_addr, 1'b0};
    endfunction

    localparam logic [7:0] CODEC_WRITE_ADDR = write_addr_byte(CODEC_DEVICE_ADDR);

    // Pack a table entry as {reg[6:0], data[8:0]}
    function automatic logic [ENTRY_W-1:0] make_entry(input logic [6:0] reg_num, input logic [8:0] data);
        return {reg_num, data};
    endfunction

endpackage

// File: rtl/codec_config_rom.sv
// rtl/codec_config_rom.sv - fixed SSM2603 power-on register table
module codec_config_rom
    import codec_config_sequencer_pkg::*;
(
    input  logic [3:0]         index,
    output logic [ENTRY_W-1:0] entry
);

    // Table lookup; unused indices return an all-zero entry
    always_comb begin
        entry = '0;
        case (index)
            4'd0:    entry = make_entry(REG_SW_RESET,     9'h000);
            4'd1:    entry = make_entry(REG_POWER_MGMT,   9'h072);
            4'd2:    entry = make_entry(REG_LOUT_VOL,     9'h179);
            4'd3:    entry = make_entry(REG_ROUT_VOL,     9'h179);
            4'd4:    entry = make_entry(REG_ANALOG_PATH,  9'h012);
            4'd5:    entry = make_entry(REG_DIGITAL_PATH, 9'h000);
            4'd6:    entry = make_entry(REG_DIGITAL_IF,   9'h002);
            4'd7:    entry = make_entry(REG_SAMPLING,     9'h000);
            4'd8:    entry = make_entry(REG_ACTIVE,       9'h001);
            4'd9:    entry = make_entry(REG_POWER_MGMT,   9'h062);
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/codec_config_sequencer.sv
// rtl/codec_config_sequencer.sv - drives i2c_master through the SSM2603 power-on register writes
module codec_config_sequencer
    import codec_config_sequencer_pkg::*;
#(
    parameter logic [6:0]  DEVICE_ADDR   = CODEC_DEVICE_ADDR,
    parameter int          NUM_ENTRIES   = 10,
    parameter int          SETTLE_INDEX  = 8,
    parameter logic [15:0] SETTLE_CYCLES = 16'd1000,
    parameter int          MAX_RETRIES   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic       i2c_ready,
    input  logic       i2c_error,
    output logic       i2c_start,
    output logic       i2c_write,
    output logic       i2c_end,
    output logic       i2c_read,
    output logic [7:0] i2c_tx_data,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] entry_index,
    output logic [1:0] retry_count
);

    localparam logic [7:0]  ADDR_BYTE   = write_addr_byte(DEVICE_ADDR);
    localparam logic [3:0]  LAST_INDEX  = 4'(NUM_ENTRIES - 1);
    localparam logic [3:0]  SETTLE_IDX  = 4'(SETTLE_INDEX);
    localparam logic [1:0]  RETRY_LIMIT = 2'(MAX_RETRIES);
    localparam logic [15:0] SETTLE_LOAD = SETTLE_CYCLES - 16'd1;

    state_e       state_q, state_d;
    logic         wait_q, wait_d;     // 0: issue phase, 1: waiting for master completion
    logic         first_q, first_d;   // strobe cycle, master ready not yet meaningful
    logic [3:0]   entry_q, entry_d;
    logic [1:0]   retry_q, retry_d;
    logic [15:0]  cnt_q, cnt_d;
    logic         start_q, start_d;
    logic         write_q, write_d;
    logic         end_q, end_d;
    logic [7:0]   tx_q, tx_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         fail_q, fail_d;

    logic [ENTRY_W-1:0] rom_entry;
    logic [6:0]         rom_reg;
    logic [8:0]         rom_data;

    codec_config_rom u_rom (
        .index (entry_q),
        .entry (rom_entry)
    );

    assign rom_reg  = rom_entry[15:9];
    assign rom_data = rom_entry[8:0];

    // Next-state and registered-output logic for the sequencer
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        first_d = first_q;
        entry_d = entry_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        write_d = 1'b0;
        end_d   = 1'b0;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        fail_d  = fail_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (go) begin
                    done_d  = 1'b0;
                    fail_d  = 1'b0;
                    busy_d  = 1'b1;
                    entry_d = 4'd0;
                    retry_d = 2'd0;
                    wait_d  = 1'b0;
                    if (SETTLE_IDX == 4'd0) begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end

            ST_SETTLE: begin
                if (cnt_q == 16'd0) begin
                    state_d = ST_START;
                    wait_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end

            ST_START, ST_ADDR, ST_REG, ST_DATA, ST_STOP, ST_ERR_STOP: begin
                if (!wait_q) begin
                    if (i2c_ready) begin
                        wait_d  = 1'b1;
                        first_d = 1'b1;
                        case (state_q)
                            ST_START: start_d = 1'b1;
                            ST_ADDR: begin
                                write_d = 1'b1;
                                tx_d    = ADDR_BYTE;
                            end
                            ST_REG: begin
                                write_d = 1'b1;
                                tx_d    = {rom_reg, rom_data[8]};
                            end
                            ST_DATA: begin
                                write_d = 1'b1;
                                tx_d    = rom_data[7:0];
                            end
                            default: end_d = 1'b1;
                        endcase
                    end
                end else if (first_q) begin
                    first_d = 1'b0;
                end else if (i2c_ready) begin
                    wait_d = 1'b0;
                    case (state_q)
                        ST_START: state_d = i2c_error ? ST_ERR_STOP : ST_ADDR;
                        ST_ADDR:  state_d = i2c_error ? ST_ERR_STOP : ST_REG;
                        ST_REG:   state_d = i2c_error ? ST_ERR_STOP : ST_DATA;
                        ST_DATA:  state_d = i2c_error ? ST_ERR_STOP : ST_STOP;
                        ST_STOP:  state_d = i2c_error ? ST_ERR_STOP : ST_NEXT;
                        default: begin
                            // Recovery STOP: its own error status is moot, the entry is retried or abandoned
                            if (retry_q < RETRY_LIMIT) begin
                                retry_d = retry_q + 2'd1;
                                state_d = ST_START;
                            end else begin
                                state_d = ST_FAIL;
                                busy_d  = 1'b0;
                                fail_d  = 1'b1;
                            end
                        end
                    endcase
                end
            end

            ST_NEXT: begin
                retry_d = 2'd0;
                wait_d  = 1'b0;
                if (entry_q == LAST_INDEX) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    entry_d = entry_q + 4'd1;
                    if (entry_q + 4'd1 == SETTLE_IDX) begin
                        state_d = ST_SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops strobes immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wait_q  <= 1'b0;
            first_q <= 1'b0;
            entry_q <= 4'd0;
            retry_q <= 2'd0;
            cnt_q   <= 16'd0;
            start_q <= 1'b0;
            write_q <= 1'b0;
            end_q   <= 1'b0;
            tx_q    <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            first_q <= first_d;
            entry_q <= entry_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            write_q <= write_d;
            end_q   <= end_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
        end
    end

    assign i2c_start   = start_q;
    assign i2c_write   = write_q;
    assign i2c_end     = end_q;
    assign i2c_read    = 1'b0;
    assign i2c_tx_data = tx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fail        = fail_q;
    assign entry_index = entry_q;
    assign retry_count = retry_q;

endmodule
